bitwise_logic_unit: RTL and testbench
=====================================

# bitwise_logic_unit

Parametrised, registered successor to the 8-bit controlled inverter: a WIDTH-bit bitwise logic unit with an opcode, a controlled output inversion, a running XOR accumulator, and a 2-entry output buffer behind a valid/ready handshake. It sits between the register file read ports and the writeback mux of the 8-bit CPU datapath. It can also be instantiated at other widths for flag and mask logic. Results carry zero and parity flags alongside the data.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥ 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- in_valid  input  1  operand/opcode present
- in_ready  output  1  unit accepts a transaction this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  operation select
- in_enable  input  1  invert the result when 1
- out_valid  output  1  out_z/out_zero/out_parity hold a result
- out_ready  input  1  consumer takes the result this cycle
- out_z  output  WIDTH  result
- out_zero  output  1  out_z == 0
- out_parity  output  1  XOR-reduction of out_z
- acc_q  output  WIDTH  current accumulator value

## Operation
- Accept: an edge with in_valid && in_ready.
- Raw result r by in_op:
  - 000 A
  - 001 A&B
  - 010 A|B
  - 011 A^B
  - 100 A&~B
  - 101 A|~B
  - 110 B
  - 111 A^acc_q
- Stored result z = in_enable ? ~r : r. Flags are computed from z, not r.
- Accumulator: on accepting op 111, acc_q <= r, the uninverted value. All other ops leave acc_q unchanged. in_enable never affects acc_q.
- Output buffer: 2-entry FIFO holding {z, zero, parity}. Occupancy count is 0..2. The head entry drives out_z/out_zero/out_parity.
- in_ready = rst_n && (count != 2). It comes from registered state only, with no combinational path from out_ready.
- out_valid = (count != 0).
- Pop: an edge with out_valid && out_ready.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged; head advances and the new entry is appended.
- Push and pop at count 1: the new entry becomes the head on the next cycle.
- Push at count 2 cannot occur, because in_ready is 0.
- When out_valid = 0, out_z, out_zero and out_parity are 0.

## Timing
- Reset (rst_n low at an edge):
  - count = 0, acc_q = 0
  - out_valid = 0, out_z = 0, out_zero = 0, out_parity = 0
  - in_ready = 0 while rst_n is low.
  - Buffered entries are discarded, including mid-stream. A transaction presented in the same cycle as reset is not accepted.
- Latency: a transaction accepted at edge k appears on the outputs after edge k when the buffer was empty, or at count 1 with a simultaneous pop.
- Throughput: 1 transaction per cycle while out_ready stays high.
- Backpressure: with out_ready low, two transactions are absorbed, then in_ready drops after the second accept. in_ready rises the cycle after the first pop.
- Back-to-back op 111: each uses the acc_q value updated by the previous accept (no hazard, since acc_q updates at the accept edge).
- out_z, out_zero and out_parity are held stable while out_valid && !out_ready.

## Test plan
- Reset/invert sweep (WIDTH=8), in_op=000, out_ready=1, cycling A∈{00,FF} and enable∈{0,1}:
  - Outputs are 00, FF, FF, 00.
  - out_zero is 1 for the 00 results; out_parity is 0 throughout.
  - All outputs are 0 during reset.
- Op coverage with A=C5, B=3A, enable=0:
  - Expected results for ops 000..110: C5, 00, FF, FF, C5, C5, 3A.
  - Repeat with enable=1: every result is bitwise inverted; out_zero=1 only for AND-inverted → no, out_zero=1 only where the inverted result is 00 (A|B and A^B inverted).
- Accumulator: from reset, op 111 with A=0F, then A=F0, then A=FF, enable=1 on the second:
  - out_z = 0F, 00 (inverted FF), 00.
  - acc_q = 0F, FF, 00.
- Backpressure: hold out_ready=0 and present 3 transactions (A=11, 22, 33, op 000):
  - in_ready drops after the 2nd accept; out_z holds 11.
  - Raise out_ready: outputs are 11, 22, 33 in order, with no loss or duplication.
- Simultaneous push/pop at count 1: a continuous stream with out_ready=1 shows 1-cycle latency and in_ready stays 1 throughout.
- Mid-stream reset: buffer full (count=2) and acc_q=5A, then assert rst_n=0 for 1 cycle:
  - out_valid=0, acc_q=00, in_ready=0 during reset.
  - Stale entries never appear on the outputs.

Source files
------------

// File: rtl/bitwise_logic_unit.sv
// WIDTH-bit bitwise logic unit: opcode-selected logic op, optional output inversion,
// running XOR accumulator, and a 2-entry result buffer with zero/parity flags.
module bitwise_logic_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_enable,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic             out_zero,
   output logic             out_parity,
   output logic [WIDTH-1:0] acc_q
);

   localparam int EW = WIDTH + 2;

   typedef enum logic [2:0] {
      OP_A      = 3'b000,
      OP_AND    = 3'b001,
      OP_OR     = 3'b010,
      OP_XOR    = 3'b011,
      OP_ANDN   = 3'b100,
      OP_ORN    = 3'b101,
      OP_B      = 3'b110,
      OP_ACCXOR = 3'b111
   } op_e;

   logic [EW-1:0]    mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] res;
   logic [EW-1:0]    entry;
   logic [EW-1:0]    head;
   logic             push;
   logic             pop;

   always_comb begin
      raw = in_a;
      case (op_e'(in_op))
         OP_A:      raw = in_a;
         OP_AND:    raw = in_a & in_b;
         OP_OR:     raw = in_a | in_b;
         OP_XOR:    raw = in_a ^ in_b;
         OP_ANDN:   raw = in_a & ~in_b;
         OP_ORN:    raw = in_a | ~in_b;
         OP_B:      raw = in_b;
         OP_ACCXOR: raw = in_a ^ acc_q;
         default:   raw = in_a;
      endcase
   end

   // Flags describe the stored (possibly inverted) value, not the raw op result.
   assign res   = in_enable ? ~raw : raw;
   assign entry = {^res, (res == '0), res};

   // Handshake: a beat transfers on any rising edge where valid && ready are both high;
   // valid never waits on ready, and in_ready depends only on rst_n and registered count.
   assign in_ready  = rst_n && (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         acc_q  <= '0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= entry;
            wr_ptr      <= ~wr_ptr;
            if (op_e'(in_op) == OP_ACCXOR) acc_q <= raw;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Outputs read as zero whenever the buffer is empty.
   assign head       = out_valid ? mem[rd_ptr] : '0;
   assign out_z      = head[WIDTH-1:0];
   assign out_zero   = head[WIDTH];
   assign out_parity = head[WIDTH+1];

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: directed test-plan sequences plus
// randomized traffic, all compared against a queue-based reference model.
module tb_bitwise_logic_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [2:0]   in_op;
   logic         in_enable;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_z;
   logic         out_zero;
   logic         out_parity;
   logic [W-1:0] acc_q;

   always #5 clk = ~clk;

   bitwise_logic_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_enable  (in_enable),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_z      (out_z),
      .out_zero   (out_zero),
      .out_parity (out_parity),
      .acc_q      (acc_q)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Model state: expected buffer contents {parity, zero, z} and accumulator.
   logic [W+1:0] exp_q[$];
   logic [W-1:0] m_acc = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_raw(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input int op, input logic [W-1:0] acc);
      case (op)
         0:       return a;
         1:       return a & b;
         2:       return a | b;
         3:       return a ^ b;
         4:       return a & ~b;
         5:       return a | ~b;
         6:       return b;
         default: return a ^ acc;
      endcase
   endfunction

   // One clock: check outputs at negedge against model, then advance model at posedge.
   task automatic cycle();
      logic         push;
      logic         pop;
      logic [W-1:0] r;
      logic [W-1:0] z;
      logic         zf;
      logic         pf;
      @(negedge clk);
      check("in_ready", in_ready, (rst_n && exp_q.size() < 2));
      check("out_valid", out_valid, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("out_z", out_z, exp_q[0][W-1:0]);
         check("out_zero", out_zero, exp_q[0][W]);
         check("out_parity", out_parity, exp_q[0][W+1]);
      end else begin
         check("out_z_idle", out_z, 0);
         check("out_flags_idle", {out_parity, out_zero}, 0);
      end
      check("acc_q", acc_q, m_acc);
      push = in_valid && rst_n && (exp_q.size() < 2);
      pop  = rst_n && (exp_q.size() != 0) && out_ready;
      r    = ref_raw(in_a, in_b, int'(in_op), m_acc);
      z    = in_enable ? ~r : r;
      zf   = (z == 0);
      pf   = ($countones(z) % 2) == 1;
      @(posedge clk);
      if (!rst_n) begin
         exp_q.delete();
         m_acc = '0;
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (push) begin
            exp_q.push_back({pf, zf, z});
            if (in_op == 3'd7) m_acc = r;
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic en, input logic ordy);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_op     = op;
      in_enable = en;
      out_ready = ordy;
      cycle();
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      drive(1'b1, 8'hEE, 8'h11, 3'd0, 1'b0, 1'b1);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] sweep_a[2];
      sweep_a[0] = 8'h00;
      sweep_a[1] = 8'hFF;
      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_enable = 1'b0; out_ready = 1'b0;
      repeat (3) drive(1'b1, 8'hAA, 8'h55, 3'd1, 1'b0, 1'b1);
      rst_n = 1'b1;

      // Invert sweep: expected 00, FF, FF, 00
      for (int i = 0; i < 2; i++)
         for (int e = 0; e < 2; e++)
            drive(1'b1, sweep_a[i], 8'h00, 3'd0, e[0], 1'b1);
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

      // Op coverage, both polarities
      for (int e = 0; e < 2; e++)
         for (int op = 0; op < 7; op++)
            drive(1'b1, 8'hC5, 8'h3A, op[2:0], e[0], 1'b1);
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

      // Accumulator chain from reset
      reset_pulse();
      drive(1'b1, 8'h0F, 8'h00, 3'd7, 1'b0, 1'b1);
      check("acc_step1", acc_q, 8'h0F);
      drive(1'b1, 8'hF0, 8'h00, 3'd7, 1'b1, 1'b1);
      check("acc_step2", acc_q, 8'hFF);
      drive(1'b1, 8'hFF, 8'h00, 3'd7, 1'b0, 1'b1);
      check("acc_step3", acc_q, 8'h00);
      check("acc_step3_z", out_z, 8'h00);
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

      // Backpressure: two absorbed, third held off until a pop
      drive(1'b1, 8'h11, 8'h00, 3'd0, 1'b0, 1'b0);
      drive(1'b1, 8'h22, 8'h00, 3'd0, 1'b0, 1'b0);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_head_held", out_z, 8'h11);
      drive(1'b1, 8'h33, 8'h00, 3'd0, 1'b0, 1'b0);
      drive(1'b1, 8'h33, 8'h00, 3'd0, 1'b0, 1'b1);
      check("bp_in_ready_back", in_ready, 1'b1);
      drive(1'b1, 8'h33, 8'h00, 3'd0, 1'b0, 1'b1);
      repeat (3) drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

      // Continuous stream with out_ready high
      repeat (20) drive(1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                        1'($urandom), 1'b1);
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

      // Mid-stream reset with a full buffer
      reset_pulse();
      drive(1'b1, 8'h5A, 8'h00, 3'd7, 1'b0, 1'b0);
      drive(1'b1, 8'h77, 8'h00, 3'd0, 1'b0, 1'b0);
      check("mid_acc_5a", acc_q, 8'h5A);
      check("mid_full", in_ready, 1'b0);
      rst_n = 1'b0;
      drive(1'b1, 8'h99, 8'h00, 3'd7, 1'b0, 1'b1);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_acc", acc_q, 8'h00);
      check("mid_rst_in_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      repeat (3) drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
               3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      rst_n = 1'b1;
      repeat (3) drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
